// File: rtl/mem_arbiter_pkg.sv
// Shared types for the imem/dmem to backing-memory arbiter.
package arbiter_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

    typedef struct packed {
        rv32i_word  addr;
        rv32i_word  wdata;
        logic [3:0] wmask;
        logic       write;
    } req_t;

endpackage

// File: rtl/mem_arbiter_req_latch.sv
// Holds the granted request; the backing-memory port is driven only from here.
module mem_arbiter_req_latch
    import arbiter_types::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic grant_i,
    input  req_t req_i,
    output req_t req_o
);

    req_t req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (grant_i) begin
            req_q <= req_i;
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serializing imem fetches and dmem loads/stores onto one
// word-wide backing-memory port, with a one-cycle registered response per request.
module mem_arbiter
    import arbiter_types::*;
#(
    parameter logic FETCH_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_read,
    input  logic [31:0] imem_address,
    output logic        imem_resp,
    output logic [31:0] imem_rdata,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_resp,
    output logic [31:0] dmem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);

    arb_state_t state_q, state_d;
    grant_t     last_grant_q, last_grant_d;
    grant_t     sel;
    logic       grant_strobe;
    req_t       req_d, req_q;
    rv32i_word  imem_rdata_q, dmem_rdata_q;
    logic       imem_resp_q, dmem_resp_q;
    logic       dmem_pending;
    logic       busy;

    assign dmem_pending = dmem_read | dmem_write;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_strobe = 1'b0;
        sel          = GRANT_I;
        req_d        = '0;

        unique case (state_q)
            IDLE: begin
                if (imem_read && dmem_pending) begin
                    sel = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
                end else if (dmem_pending) begin
                    sel = GRANT_D;
                end
                if (imem_read || dmem_pending) begin
                    grant_strobe = 1'b1;
                    last_grant_d = sel;
                    state_d      = (sel == GRANT_I) ? BUSY_I : BUSY_D;
                end
                // A load+store request resolves as a store; reads carry zero mask/data.
                if (sel == GRANT_I) begin
                    req_d.addr = imem_address;
                end else begin
                    req_d.addr  = dmem_address;
                    req_d.write = dmem_write;
                    req_d.wmask = dmem_write ? dmem_wmask : 4'b0000;
                    req_d.wdata = dmem_write ? dmem_wdata : 32'h0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= FETCH_FIRST ? GRANT_D : GRANT_I;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
            imem_resp_q  <= 1'b0;
            dmem_resp_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            imem_resp_q  <= (state_q == BUSY_I) && mem_resp;
            dmem_resp_q  <= (state_q == BUSY_D) && mem_resp;
            if ((state_q == BUSY_I) && mem_resp) begin
                imem_rdata_q <= mem_rdata;
            end
            if ((state_q == BUSY_D) && mem_resp) begin
                dmem_rdata_q <= mem_rdata;
            end
        end
    end

    mem_arbiter_req_latch u_req_latch (
        .clk     (clk),
        .rst_n   (rst),
        .grant_i (grant_strobe),
        .req_i   (req_d),
        .req_o   (req_q)
    );

    assign busy        = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign mem_read    = busy && !req_q.write;
    assign mem_write   = busy && req_q.write;
    assign mem_wmask   = req_q.wmask;
    assign mem_address = req_q.addr;
    assign mem_wdata   = req_q.wdata;

    assign imem_resp  = imem_resp_q;
    assign dmem_resp  = dmem_resp_q;
    assign imem_rdata = imem_rdata_q;
    assign dmem_rdata = dmem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: expected memory requests and port responses are queued by
// the stimulus; a memory model and a response monitor pop and compare them.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_read = 1'b0;
    logic [31:0] imem_address = '0;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        dmem_read = 1'b0;
    logic        dmem_write = 1'b0;
    logic [3:0]  dmem_wmask = '0;
    logic [31:0] dmem_address = '0;
    logic [31:0] dmem_wdata = '0;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp = 1'b0;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
    } mem_exp_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } resp_exp_t;

    mem_exp_t  exp_mem[$];
    resp_exp_t exp_resp[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mcnt = 0;
    int mresp_cycle = 0;
    mem_exp_t cur;
    logic [31:0] last_i = '0;
    logic [31:0] last_d = '0;

    mem_arbiter #(.FETCH_FIRST(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_wmask   (dmem_wmask),
        .dmem_address (dmem_address),
        .dmem_wdata   (dmem_wdata),
        .dmem_resp    (dmem_resp),
        .dmem_rdata   (dmem_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wmask    (mem_wmask),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_i(input logic [31:0] addr, input int lat, input logic [31:0] data);
        exp_mem.push_back('{1'b0, addr, 4'b0000, 32'h0, lat, data});
        exp_resp.push_back('{1'b0, data});
    endtask

    task automatic push_d(input logic wr, input logic [31:0] addr, input logic [3:0] wm,
                          input logic [31:0] wd, input int lat, input logic [31:0] data);
        exp_mem.push_back('{wr, addr, wr ? wm : 4'b0000, wr ? wd : 32'h0, lat, data});
        exp_resp.push_back('{1'b1, data});
    endtask

    task automatic wait_resp(input logic port);
        logic got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            got = port ? dmem_resp : imem_resp;
        end
        check(port ? "dmem_resp_timeout" : "imem_resp_timeout", {31'b0, got}, 32'd1);
    endtask

    // Backing memory: takes each new request's expected fields and latency from exp_mem.
    always @(negedge clk) begin
        if (!rst) begin
            mem_resp = 1'b0;
            mcnt = 0;
        end else if (mem_resp) begin
            mem_resp = 1'b0;
            mcnt = 0;
        end else if (mem_read || mem_write) begin
            if (mcnt == 0) begin
                if (exp_mem.size() == 0) begin
                    check("mem_unexpected_req", 32'd1, 32'd0);
                    cur = '{1'b0, 32'h0, 4'h0, 32'h0, 1, 32'h0};
                end else begin
                    cur = exp_mem.pop_front();
                    check("mem_write", {31'b0, mem_write}, {31'b0, cur.write});
                    check("mem_read", {31'b0, mem_read}, {31'b0, ~cur.write});
                    check("mem_address", mem_address, cur.addr);
                    check("mem_wmask", {28'b0, mem_wmask}, {28'b0, cur.wmask});
                    check("mem_wdata", mem_wdata, cur.wdata);
                end
            end
            mcnt++;
            if (mcnt >= cur.lat) begin
                mem_resp = 1'b1;
                mem_rdata = cur.rdata;
                mresp_cycle = cyc;
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rst && (imem_resp || dmem_resp)) begin
            resp_exp_t e;
            check("resp_both_ports", {31'b0, imem_resp & dmem_resp}, 32'd0);
            check("resp_cycle", cyc, mresp_cycle + 1);
            check("mem_idle_at_resp", {30'b0, mem_read, mem_write}, 32'd0);
            if (exp_resp.size() == 0) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_resp.pop_front();
                check("resp_port", {31'b0, dmem_resp}, {31'b0, e.port});
                if (e.port) begin
                    check("dmem_rdata", dmem_rdata, e.data);
                    check("imem_rdata_held", imem_rdata, last_i);
                    last_d = e.data;
                end else begin
                    check("imem_rdata", imem_rdata, e.data);
                    check("dmem_rdata_held", dmem_rdata, last_d);
                    last_i = e.data;
                end
            end
        end
    end

    initial begin
        logic got;
        repeat (2) @(negedge clk);
        check("reset_outputs", {imem_resp, dmem_resp, mem_read, mem_write, mem_wmask} , 8'h0);
        check("reset_rdata", imem_rdata | dmem_rdata | mem_address | mem_wdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Fetch, k=3.
        push_i(32'h0000_1000, 3, 32'hDEAD_BEEF);
        imem_address = 32'h0000_1000;
        imem_read = 1'b1;
        wait_resp(1'b0);
        imem_read = 1'b0;
        @(negedge clk);

        // Store, k=2.
        push_d(1'b1, 32'h0000_2004, 4'b0011, 32'h1234_5678, 2, 32'h5A5A_0001);
        dmem_address = 32'h0000_2004;
        dmem_wmask = 4'b0011;
        dmem_wdata = 32'h1234_5678;
        dmem_write = 1'b1;
        wait_resp(1'b1);
        dmem_write = 1'b0;
        @(negedge clk);

        // Both held continuously: last grant was dmem, so I, D, I, D.
        push_i(32'h0000_0100, 1, 32'hA1A1_0001);
        push_d(1'b0, 32'h0000_0200, 4'hF, 32'hFFFF_FFFF, 2, 32'hD1D1_0001);
        push_i(32'h0000_0104, 1, 32'hA1A1_0002);
        push_d(1'b0, 32'h0000_0204, 4'hF, 32'hFFFF_FFFF, 2, 32'hD1D1_0002);
        fork
            begin
                imem_address = 32'h0000_0100;
                imem_read = 1'b1;
                wait_resp(1'b0);
                imem_address = 32'h0000_0104;
                wait_resp(1'b0);
                imem_read = 1'b0;
            end
            begin
                dmem_address = 32'h0000_0200;
                dmem_wmask = 4'hF;
                dmem_wdata = 32'hFFFF_FFFF;
                dmem_read = 1'b1;
                wait_resp(1'b1);
                dmem_address = 32'h0000_0204;
                wait_resp(1'b1);
                dmem_read = 1'b0;
            end
        join
        @(negedge clk);

        // k=1, then a new fetch in the first IDLE cycle.
        push_i(32'h0000_4000, 1, 32'h0000_4444);
        imem_address = 32'h0000_4000;
        imem_read = 1'b1;
        wait_resp(1'b0);
        imem_read = 1'b0;
        @(negedge clk);
        check("idle_after_resp", {30'b0, mem_read, imem_resp}, 32'd0);
        push_i(32'h0000_4004, 2, 32'h0000_5555);
        imem_address = 32'h0000_4004;
        imem_read = 1'b1;
        @(posedge clk);
        #1 check("mem_read_next_cycle", {31'b0, mem_read}, 32'd1);
        wait_resp(1'b0);
        imem_read = 1'b0;
        @(negedge clk);

        // Reset during BUSY_D abandons the load.
        exp_mem.push_back('{1'b0, 32'h0000_3000, 4'h0, 32'h0, 10, 32'h3333_3333});
        dmem_address = 32'h0000_3000;
        dmem_read = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = mem_read;
        end
        check("busy_d_reached", {31'b0, got}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset_ctrl", {imem_resp, dmem_resp, mem_read, mem_write, mem_wmask}, 8'h0);
        check("async_reset_data", imem_rdata | dmem_rdata | mem_address | mem_wdata, 32'h0);
        last_i = '0;
        last_d = '0;
        dmem_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_i(32'h0000_6000, 2, 32'h6666_0006);
        imem_address = 32'h0000_6000;
        imem_read = 1'b1;
        wait_resp(1'b0);
        imem_read = 1'b0;
        @(negedge clk);

        // Load+store together resolves as a store.
        push_d(1'b1, 32'h0000_7008, 4'b1111, 32'hCAFE_F00D, 1, 32'h0000_0077);
        dmem_address = 32'h0000_7008;
        dmem_wmask = 4'b1111;
        dmem_wdata = 32'hCAFE_F00D;
        dmem_read = 1'b1;
        dmem_write = 1'b1;
        wait_resp(1'b1);
        dmem_read = 1'b0;
        dmem_write = 1'b0;

        repeat (5) @(negedge clk);
        check("exp_resp_drained", exp_resp.size(), 32'd0);
        check("exp_mem_drained", exp_mem.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder for the pipelined RV32I core. It answers the core's instruction-fetch (imem) and data (dmem) request/response ports and serializes both onto one word-wide backing-memory port. Requests are arbitered round-robin, latched, and issued from registers. Each request gets a single-cycle registered response pulse.

## Interface
Parameters:
- FETCH_FIRST, 1: initial last-grant value. With 1, the first simultaneous conflict after reset goes to imem; with 0, it goes to dmem.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- imem_read  in  1  fetch request, held until imem_resp
- imem_address  in  32  fetch address, stable while imem_read is high
- imem_resp  out  1  one-cycle pulse: imem_rdata valid
- imem_rdata  out  32  fetched word
- dmem_read  in  1  data load request
- dmem_write  in  1  data store request
- dmem_wmask  in  4  byte enables for the store
- dmem_address  in  32  data address
- dmem_wdata  in  32  store data
- dmem_resp  out  1  one-cycle pulse: load data valid or store done
- dmem_rdata  out  32  loaded word
- mem_read  out  1  backing read, held until mem_resp
- mem_write  out  1  backing write, held until mem_resp
- mem_wmask  out  4  backing byte enables; 0 on reads
- mem_address  out  32  backing address
- mem_wdata  out  32  backing write data; 0 on reads
- mem_resp  in  1  one-cycle completion pulse from memory
- mem_rdata  in  32  read data, valid while mem_resp is high

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE transitions:
  - imem only pending -> BUSY_I.
  - dmem only pending -> BUSY_D.
  - Both pending -> grant the port not granted last, then update the last-grant bit.
- On a grant, latch the address, write flag, mask and wdata into request registers. The mem_* outputs are driven only from these registers.
- A dmem request with both dmem_read and dmem_write high is illegal. It is treated as a write.
- BUSY_x transitions:
  - Hold mem_read or mem_write until mem_resp.
  - On mem_resp, capture mem_rdata into the rdata register of the granted port, drop mem_read/mem_write, and go to RESP.
  - A mem_resp arriving in IDLE or RESP is ignored.
- RESP: pulse the granted port's resp for exactly one cycle, then return to IDLE.
- The non-granted port's resp stays 0 throughout.
- imem_rdata and dmem_rdata keep their last captured value until the next capture for that port.
- The requester may present a new request in the cycle after its resp. IDLE samples it then.
- Request inputs are not sampled in BUSY_x or RESP, so input changes during these states have no effect.

## Timing
- Reset value of every output is 0. Reset also clears both rdata registers, sets state to IDLE, and sets last-grant from FETCH_FIRST (1 means last grant was dmem).
- Reset mid-transaction abandons the transaction and produces no resp. The backing memory must tolerate the dropped request.
- Request seen in IDLE at cycle 0:
  - mem_read/mem_write high at cycle 1.
  - mem_resp earliest at cycle 1, in general at cycle k ≥ 1.
  - Port resp high at cycle k+1.
  - IDLE at cycle k+2.
- Minimum round trip is 2 cycles. Back-to-back throughput is one request per k+2 cycles.
- mem_read/mem_write are low in the cycle after mem_resp. There is always at least one idle backing cycle between transactions.

## Structure
- Package arbiter_types holds:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D, RESP}.
  - grant_t enum {GRANT_I, GRANT_D}.
  - req_t struct {addr, wdata, wmask, write}.
- Address and data types use rv32i_word.
- One sub-module is natural: mem_arbiter_req_latch, which captures and holds req_t on a grant strobe and clears on reset.

## Test plan
- imem_read with address 0x0000_1000; memory returns 0xDEAD_BEEF at k=3 -> mem_address=0x1000, mem_read high cycles 1–3, imem_resp high only at cycle 4 with imem_rdata=0xDEAD_BEEF, dmem_resp 0 throughout.
- dmem_write with address 0x0000_2004, wmask 4'b0011, wdata 0x1234_5678 -> mem_write=1, mem_wmask=0011, mem_wdata=0x1234_5678, mem_read=0; dmem_resp one cycle after mem_resp.
- imem and dmem both asserted at the same cycle, FETCH_FIRST=1 -> imem served first, then dmem. Hold both asserted continuously -> grants alternate I, D, I, D.
- mem_resp in the same cycle mem_read rises (k=1) -> resp at cycle 2, mem_read low at cycle 2, IDLE at cycle 3. A new imem request presented at cycle 3 -> mem_read high at cycle 4.
- rst low during BUSY_D with address 0x0000_3000 -> all outputs 0 immediately (asynchronous), no dmem_resp. After release, an imem request is served normally.
- dmem_read and dmem_write both high with wmask 4'b1111 -> only mem_write is asserted, with mem_wmask=1111.
